// File: rtl/timer_prescaler.sv
// Timer clock-source select and prescaler: one of four slow asynchronous sources is
// synchronised into sys_clk, and its rising edges are counted into a tick every M edges.
module timer_prescaler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_ssel,
    input  logic [3:0]  cfg_dsel,
    input  logic [3:0]  clk_src,
    output logic [1:0]  ssel,
    output logic [3:0]  dsel,
    output logic        tick,
    output logic        div_out,
    output logic [14:0] pre_cnt
);

    localparam int MASK_W = $clog2(SYNC_STAGES + 2);
    localparam logic [MASK_W-1:0] MASK_LOAD = MASK_W'(SYNC_STAGES + 1);

    logic [1:0]             r_ssel;
    logic [3:0]             r_dsel;
    logic                   r_tick;
    logic                   r_div;
    logic [14:0]            r_pre_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_se;
    logic [MASK_W-1:0]      r_mask_cnt;

    logic        w_src;
    logic        w_mask;
    logic        w_edge;
    logic [3:0]  w_shamt;
    logic [14:0] w_term;
    logic        w_at_term;

    assign w_src  = clk_src[r_ssel];
    assign w_mask = |r_mask_cnt;
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_se & en & ~w_mask;

    // M = 2^shamt: A contributes 8, B contributes 1, C contributes 2*dsel[1:0]
    assign w_shamt   = {r_dsel[3], 3'b000} + {3'b000, r_dsel[2]} + {1'b0, r_dsel[1:0], 1'b0};
    assign w_term    = 15'((16'd1 << w_shamt) - 16'd1);
    assign w_at_term = (r_pre_cnt == w_term);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync <= '0;
            r_se   <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_src};
            else
                r_sync[0] <= w_src;
            r_se <= r_sync[SYNC_STAGES-1];
        end
    end

    // Blank edge detection until the pipeline holds only samples of the new source.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_mask_cnt <= '0;
        else if (cfg_load)
            r_mask_cnt <= MASK_LOAD;
        else if (w_mask)
            r_mask_cnt <= r_mask_cnt - 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ssel <= 2'd0;
            r_dsel <= 4'd0;
        end else if (cfg_load) begin
            r_ssel <= cfg_ssel;
            r_dsel <= cfg_dsel;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pre_cnt <= 15'd0;
            r_tick    <= 1'b0;
            r_div     <= 1'b0;
        end else if (!en) begin
            r_pre_cnt <= 15'd0;
            r_tick    <= 1'b0;
            r_div     <= 1'b0;
        end else if (cfg_load) begin
            r_pre_cnt <= 15'd0;
            r_tick    <= 1'b0;
        end else if (w_edge) begin
            if (w_at_term) begin
                r_pre_cnt <= 15'd0;
                r_tick    <= 1'b1;
                r_div     <= ~r_div;
            end else begin
                r_pre_cnt <= r_pre_cnt + 15'd1;
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign ssel    = r_ssel;
    assign dsel    = r_dsel;
    assign tick    = r_tick;
    assign div_out = r_div;
    assign pre_cnt = r_pre_cnt;

endmodule

// File: tb/tb_timer_prescaler.sv
// Bench for timer_prescaler: directed scenarios plus randomized traffic, checked every
// cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_timer_prescaler;

    localparam int N = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_ssel = 2'd0;
    logic [3:0]  cfg_dsel = 4'd0;
    logic [3:0]  clk_src = 4'd0;
    logic [1:0]  ssel;
    logic [3:0]  dsel;
    logic        tick;
    logic        div_out;
    logic [14:0] pre_cnt;

    timer_prescaler #(.SYNC_STAGES(N)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .cfg_load(cfg_load),
        .cfg_ssel(cfg_ssel),
        .cfg_dsel(cfg_dsel),
        .clk_src (clk_src),
        .ssel    (ssel),
        .dsel    (dsel),
        .tick    (tick),
        .div_out (div_out),
        .pre_cnt (pre_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int nprint = 0;
    int tick_cnt = 0;

    // Reference model: keeps the selected-source value sampled at every clock edge;
    // a rise counts when the two samples are both taken from the current source and
    // N edges have passed since the later one.
    int         mt;
    int         mk;
    int         mm;
    int         m_last_load;
    bit         m_hist [16];
    bit         m_rise;
    logic [1:0] m_ssel;
    logic [3:0] m_dsel;
    int         m_cnt;
    bit         m_tick;
    bit         m_div;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mt = 0;
            m_last_load = -100;
            for (int i = 0; i < 16; i++) m_hist[i] = 1'b0;
            m_ssel = 2'd0;
            m_dsel = 4'd0;
            m_cnt  = 0;
            m_tick = 1'b0;
            m_div  = 1'b0;
        end else begin
            mt = mt + 1;
            m_hist[mt % 16] = clk_src[m_ssel];
            mk = mt - N;
            m_rise = (mk >= 1) && (mk - 1 >= m_last_load + 1)
                     && m_hist[mk % 16] && !m_hist[(mk - 1) % 16];
            mm = 1 << ((m_dsel[3] ? 8 : 0) + (m_dsel[2] ? 1 : 0) + 2 * int'(m_dsel[1:0]));
            if (cfg_load) begin
                m_last_load = mt;
            end
            if (!en) begin
                m_cnt = 0; m_tick = 1'b0; m_div = 1'b0;
            end else if (cfg_load) begin
                m_cnt = 0; m_tick = 1'b0;
            end else if (m_rise) begin
                if (m_cnt + 1 == mm) begin
                    m_cnt = 0; m_tick = 1'b1; m_div = !m_div;
                end else begin
                    m_cnt = m_cnt + 1; m_tick = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
            if (cfg_load) begin
                m_ssel = cfg_ssel;
                m_dsel = cfg_dsel;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            checks++;
            if ({ssel, dsel, tick, div_out, pre_cnt} !==
                {m_ssel, m_dsel, m_tick, m_div, 15'(m_cnt)}) begin
                errors++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model_cmp t=%0t: got ssel=%0d dsel=%0d tick=%0b div=%0b cnt=%0d, want ssel=%0d dsel=%0d tick=%0b div=%0b cnt=%0d",
                             $time, ssel, dsel, tick, div_out, pre_cnt,
                             m_ssel, m_dsel, m_tick, m_div, m_cnt);
                end
            end
            if (tick === 1'b1) tick_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic rise(input int idx);
        clk_src[idx] = 1'b1;
        step(1);
        clk_src[idx] = 1'b0;
        step(1);
    endtask

    task automatic load(input logic [1:0] s, input logic [3:0] d);
        cfg_ssel = s;
        cfg_dsel = d;
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        step(N + 2);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    int t0;
    logic d0;

    initial begin
        step(3);
        chk("reset_outputs", int'({ssel, dsel, tick, div_out, pre_cnt}), 0);
        sys_rst = 1'b0;
        en = 1'b1;
        step(2);

        // M=1 on source 0: latency and one tick per rise
        load(2'd0, 4'd0);
        t0 = tick_cnt;
        clk_src[0] = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        chk("latency_not_yet", int'(tick), 0);
        @(posedge sys_clk);
        #1;
        chk("latency_tick", int'(tick), 1);
        chk("div_after_first", int'(div_out), 1);
        step(6);
        clk_src[0] = 1'b0;
        step(8);
        for (int i = 0; i < 7; i++) begin
            clk_src[0] = 1'b1; step(8);
            clk_src[0] = 1'b0; step(8);
        end
        chk("m1_ticks", tick_cnt - t0, 8);
        chk("m1_div_even", int'(div_out), 0);

        // M=64
        load(2'd0, 4'b0011);
        t0 = tick_cnt;
        d0 = div_out;
        for (int i = 0; i < 63; i++) rise(0);
        step(3);
        chk("m64_cnt_63", int'(pre_cnt), 63);
        chk("m64_no_tick", tick_cnt - t0, 0);
        rise(0); step(3);
        chk("m64_tick", tick_cnt - t0, 1);
        chk("m64_wrap", int'(pre_cnt), 0);
        chk("m64_div_flip", int'(div_out), int'(!d0));
        for (int i = 0; i < 64; i++) rise(0);
        step(3);
        chk("m64_div_period", int'(div_out), int'(d0));

        // M=32768
        load(2'd0, 4'b1111);
        t0 = tick_cnt;
        for (int i = 0; i < 32767; i++) rise(0);
        step(3);
        chk("m32k_cnt_max", int'(pre_cnt), 32767);
        chk("m32k_no_tick", tick_cnt - t0, 0);
        rise(0); step(3);
        chk("m32k_tick", tick_cnt - t0, 1);
        chk("m32k_wrap", int'(pre_cnt), 0);

        // Switch to a source already high: no spurious edge
        load(2'd0, 4'd0);
        clk_src[2] = 1'b1;
        step(4);
        t0 = tick_cnt;
        load(2'd2, 4'd0);
        step(8);
        chk("switch_no_tick", tick_cnt - t0, 0);
        chk("switch_cnt", int'(pre_cnt), 0);
        chk("switch_ssel", int'(ssel), 2);
        clk_src[2] = 1'b0; step(3);
        clk_src[2] = 1'b1; step(4);
        chk("switch_first_tick", tick_cnt - t0, 1);
        clk_src[2] = 1'b0; step(3);

        // en drop and restart with M=4
        load(2'd0, 4'b0001);
        rise(0); rise(0); step(3);
        chk("en_cnt_before", int'(pre_cnt), 2);
        en = 1'b0;
        step(2);
        chk("en_low_cnt", int'(pre_cnt), 0);
        chk("en_low_div", int'(div_out), 0);
        en = 1'b1;
        t0 = tick_cnt;
        for (int i = 0; i < 3; i++) rise(0);
        step(3);
        chk("en_restart_no_tick", tick_cnt - t0, 0);
        chk("en_restart_cnt", int'(pre_cnt), 3);
        rise(0); step(3);
        chk("en_restart_tick", tick_cnt - t0, 1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            clk_src  = 4'($urandom);
            en       = ($urandom_range(0, 99) < 96);
            cfg_load = ($urandom_range(0, 99) < 2);
            cfg_ssel = 2'($urandom);
            cfg_dsel = 4'($urandom_range(0, 5));
            step(1);
        end
        cfg_load = 1'b0;
        en = 1'b1;
        clk_src = 4'd0;

        // Asynchronous reset mid-count
        load(2'd0, 4'b0010);
        for (int i = 0; i < 5; i++) rise(0);
        step(2);
        chk("rst_pre_cnt", int'(pre_cnt), 5);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'({ssel, dsel, tick, div_out, pre_cnt}), 0);
        step(2);
        sys_rst = 1'b0;
        step(3);
        chk("after_rst_outputs", int'({ssel, dsel, tick, div_out, pre_cnt}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
